// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - SPART bus address map, baud table and echo controller state enum
package spart_pkg;

   localparam logic [1:0] SPART_ADDR_BUF    = 2'b00;
   localparam logic [1:0] SPART_ADDR_STAT   = 2'b01;
   localparam logic [1:0] SPART_ADDR_DIV_LO = 2'b10;
   localparam logic [1:0] SPART_ADDR_DIV_HI = 2'b11;

   typedef enum logic [1:0] {
      ST_INIT_LO = 2'b00,
      ST_INIT_HI = 2'b01,
      ST_RUN     = 2'b10
   } ctrl_state_e;

   function automatic int unsigned baud_rate(input logic [1:0] cfg);
      case (cfg)
         2'b00:   return 4800;
         2'b01:   return 9600;
         2'b10:   return 19200;
         default: return 38400;
      endcase
   endfunction

   function automatic logic [15:0] baud_div(input int unsigned clk_hz, input logic [1:0] cfg);
      int unsigned d;
      d = clk_hz / (16 * baud_rate(cfg)) - 1;
      return d[15:0];
   endfunction

endpackage

// File: rtl/spart_echo_ctrl_if.sv
// rtl/spart_echo_ctrl_if.sv - SPART control/handshake signals between echo controller and SPART
interface spart_echo_ctrl_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic       rda;
   logic       tbr;

   modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
   modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_byte_fifo.sv
// rtl/spart_byte_fifo.sv - synchronous byte FIFO with occupancy count
module spart_byte_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [7:0]               din,
   input  logic                     pop,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/spart_echo_ctrl.sv
// rtl/spart_echo_ctrl.sv - SPART baud programming plus buffered rx->tx echo loop
// Macro SPART_ECHO_UPCASE_EN: transmit 0x61-0x7A with bit 5 cleared.
module spart_echo_ctrl
   import spart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned FIFO_DEPTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [1:0]                    br_cfg,
   spart_echo_ctrl_if.master             bus,
   inout  wire  [7:0]                    databus,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   ctrl_state_e state, state_nx;
   logic [1:0]  cfg_q, prog_cfg;
   logic        rx_hold, tx_hold;
   logic        do_rd, do_wr, drive;
   logic [7:0]  wdata, head, tx_byte;
   logic        full, empty;
   logic [15:0] div_live, div_prog;

   // Each call has constant arguments, so the divisor table folds to constants.
   function automatic logic [15:0] div_lut(input logic [1:0] cfg);
      case (cfg)
         2'b00:   return baud_div(CLK_FREQ_HZ, 2'b00);
         2'b01:   return baud_div(CLK_FREQ_HZ, 2'b01);
         2'b10:   return baud_div(CLK_FREQ_HZ, 2'b10);
         default: return baud_div(CLK_FREQ_HZ, 2'b11);
      endcase
   endfunction

   assign div_live = div_lut(br_cfg);
   assign div_prog = div_lut(prog_cfg);

`ifdef SPART_ECHO_UPCASE_EN
   assign tx_byte = (head >= 8'h61 && head <= 8'h7A) ? (head & 8'hDF) : head;
`else
   assign tx_byte = head;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_INIT_LO;
         cfg_q    <= 2'b00;
         prog_cfg <= 2'b00;
         rx_hold  <= 1'b0;
         tx_hold  <= 1'b0;
      end else begin
         state   <= state_nx;
         cfg_q   <= br_cfg;
         rx_hold <= do_rd;
         tx_hold <= do_wr;
         if (state == ST_INIT_LO) prog_cfg <= br_cfg;
      end
   end

   always_comb begin
      state_nx   = state;
      do_rd      = 1'b0;
      do_wr      = 1'b0;
      drive      = 1'b0;
      wdata      = 8'h00;
      bus.iocs   = 1'b0;
      bus.iorw   = 1'b1;
      bus.ioaddr = SPART_ADDR_BUF;
      // Gating on rst keeps the bus idle while held in reset, even though state is INIT_LO.
      if (!rst) begin
         case (state)
            ST_INIT_LO: begin
               bus.iocs   = 1'b1;
               bus.iorw   = 1'b0;
               bus.ioaddr = SPART_ADDR_DIV_LO;
               drive      = 1'b1;
               wdata      = div_live[7:0];
               state_nx   = ST_INIT_HI;
            end
            ST_INIT_HI: begin
               bus.iocs   = 1'b1;
               bus.iorw   = 1'b0;
               bus.ioaddr = SPART_ADDR_DIV_HI;
               drive      = 1'b1;
               wdata      = div_prog[15:8];
               state_nx   = ST_RUN;
            end
            ST_RUN: begin
               if (cfg_q != prog_cfg) begin
                  state_nx = ST_INIT_LO;
               end else if (bus.rda && !full && !rx_hold) begin
                  do_rd    = 1'b1;
                  bus.iocs = 1'b1;
               end else if (bus.tbr && !empty && !tx_hold) begin
                  do_wr    = 1'b1;
                  bus.iocs = 1'b1;
                  bus.iorw = 1'b0;
                  drive    = 1'b1;
                  wdata    = tx_byte;
               end
            end
            default: state_nx = ST_INIT_LO;
         endcase
      end
   end

   assign databus = drive ? wdata : 8'hzz;

   spart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (do_rd),
      .din   (databus),
      .pop   (do_wr),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );
endmodule
